// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memwait_state_t;

    // Destination dst produces a value that src needs; register 0 is never a dependency
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: E-stage operand forward select for one source specifier (M beats W)
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] src,
    input  logic       regwrite_m,
    input  logic [4:0] writereg_m,
    input  logic       regwrite_w,
    input  logic [4:0] writereg_w,
    output fwd_sel_t   sel
);

    // Youngest producer wins so the most recent value reaches the ALU
    always_comb begin
        sel = (regwrite_m && reg_match(writereg_m, src)) ? FWD_MEM :
              (regwrite_w && reg_match(writereg_w, src)) ? FWD_WB  : FWD_RF;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, stall/flush and memory-wait freeze for the five-stage MIPS core
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
`ifdef HAZARD_PERF_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeregE,
    input  logic [4:0]       writeregM,
    input  logic [4:0]       writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             branchD,
    input  logic             bneD,
    input  logic             jumpD,
    input  logic             pcsrcD,
    input  logic             memreqM,
    input  logic             memreadyM,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
`endif
);

    fwd_sel_t       fwd_ae;
    fwd_sel_t       fwd_be;
    memwait_state_t state_q;
    memwait_state_t state_d;
    logic           lwstall;
    logic           brstall;
    logic           memwait;
    logic           hazard;

    hazard_fwd_sel u_fwd_a (
        .src        (rsE),
        .regwrite_m (regwriteM),
        .writereg_m (writeregM),
        .regwrite_w (regwriteW),
        .writereg_w (writeregW),
        .sel        (fwd_ae)
    );

    hazard_fwd_sel u_fwd_b (
        .src        (rtE),
        .regwrite_m (regwriteM),
        .writereg_m (writeregM),
        .regwrite_w (regwriteW),
        .writereg_w (writeregW),
        .sel        (fwd_be)
    );

    // Hazard detection and freeze decision; WAIT is held exactly while memwait is high
    always_comb begin
        lwstall = memtoregE && (reg_match(rtE, rsD) || reg_match(rtE, rtD));
        brstall = (branchD || bneD) &&
                  ((regwriteE && (reg_match(writeregE, rsD) || reg_match(writeregE, rtD))) ||
                   (memtoregM && (reg_match(writeregM, rsD) || reg_match(writeregM, rtD))));
        memwait = (state_q == IDLE) ? (memreqM && !memreadyM) : !memreadyM;
        hazard  = lwstall || brstall;
        state_d = memwait ? WAIT : IDLE;
    end

    // Stall/flush/forward outputs; a frozen pipeline is never cleared and reset silences everything
    always_comb begin
        stallF    = reset && (memwait || hazard);
        stallD    = reset && (memwait || hazard);
        stallE    = reset && memwait;
        stallM    = reset && memwait;
        flushW    = reset && memwait;
        flushE    = reset && !memwait && hazard;
        flushD    = reset && !memwait && !hazard && (pcsrcD || jumpD);
        forwardAD = reset && regwriteM && reg_match(writeregM, rsD);
        forwardBD = reset && regwriteM && reg_match(writeregM, rtD);
        forwardAE = reset ? fwd_ae : FWD_RF;
        forwardBE = reset ? fwd_be : FWD_RF;
    end

    // Memory-wait state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] wait_cnt_q,  wait_cnt_d;

    // Free-running event counters that wrap naturally
    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(stallD);
        flush_cnt_d = flush_cnt_q + CNT_W'(flushE);
        wait_cnt_d  = wait_cnt_q  + CNT_W'(memwait);
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign wait_cnt  = wait_cnt_q;
`endif

endmodule
